// File: rtl/ir_fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit: FSM state encoding,
// byte-counter sizing and big-endian byte slot placement.
package ir_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  // Largest legal instruction length in bytes.
  localparam int unsigned MAX_IR_BYTES = 4;

  // Byte-counter width for an n-byte instruction: clog2(n), never below 1.
  function automatic int unsigned cnt_width(input int unsigned n_bytes);
    int unsigned w;
    w = $clog2(n_bytes);
    return (w < 1) ? 1 : w;
  endfunction

  // Counter width that covers every legal instruction length.
  localparam int unsigned CNT_W = cnt_width(MAX_IR_BYTES);

  // LSB offset of byte idx inside the instruction word; byte 0 is the MS byte.
  function automatic int unsigned byte_lsb(input int unsigned idx,
                                           input int unsigned n_bytes,
                                           input int unsigned data_w);
    return (n_bytes - 1 - idx) * data_w;
  endfunction

endpackage

// File: rtl/mar_counter.sv
// Memory address register with parallel load and +1 increment.
// Ports: clk, rst (async, active-high), load/load_val, inc, mar (current value).
// Load wins over increment; increment wraps modulo 2^ADDR_W.
module mar_counter #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] mar
);

  // Address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar <= RESET_ADDR;
    end else if (load) begin
      mar <= load_val;
    end else if (inc) begin
      mar <= mar + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/ir_mar_fetch.sv
// Multi-byte instruction fetch unit with integrated MAR.
// Ports: CLK, RESET (async, active-high); HMAR/BUS_C load the MAR when idle;
// FETCH starts a fetch when idle; MEM_RD/MEM_ACK/DATA_IN form the memory read
// handshake; BUS_DIR is the MAR; IR_OUT is the assembled instruction with a
// one-cycle IR_VALID pulse; BUSY is high while a fetch is in progress.
module ir_mar_fetch
  import ir_fetch_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       IR_BYTES   = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       HMAR,
  input  logic [ADDR_W-1:0]          BUS_C,
  input  logic                       FETCH,
  output logic                       MEM_RD,
  input  logic                       MEM_ACK,
  input  logic [DATA_W-1:0]          DATA_IN,
  output logic [ADDR_W-1:0]          BUS_DIR,
  output logic [DATA_W*IR_BYTES-1:0] IR_OUT,
  output logic                       IR_VALID,
  output logic                       BUSY
);

  localparam int unsigned IR_W  = DATA_W * IR_BYTES;
  localparam int unsigned BCW   = cnt_width(IR_BYTES);

  fetch_state_e    state, state_next;
  logic [BCW-1:0]  cnt, cnt_next;
  logic [IR_W-1:0] shadow, shadow_next;
  logic [IR_W-1:0] ir_next;
  logic            mar_load, mar_inc;

  mar_counter #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RESET_ADDR)
  ) u_mar (
    .clk      (CLK),
    .rst      (RESET),
    .load     (mar_load),
    .load_val (BUS_C),
    .inc      (mar_inc),
    .mar      (BUS_DIR)
  );

  // State, datapath and output registers; status outputs follow next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      IR_OUT   <= '0;
      IR_VALID <= 1'b0;
      MEM_RD   <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      shadow   <= shadow_next;
      IR_OUT   <= ir_next;
      IR_VALID <= (state_next == DONE);
      MEM_RD   <= (state_next == REQ);
      BUSY     <= (state_next != IDLE);
    end
  end

  // Next-state, byte capture and MAR control.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow;
    ir_next     = IR_OUT;
    mar_load    = 1'b0;
    mar_inc     = 1'b0;

    unique case (state)
      IDLE: begin
        mar_load = HMAR;
        if (FETCH) begin
          cnt_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          // Place the incoming byte in its big-endian slot.
          for (int unsigned i = 0; i < IR_BYTES; i++) begin
            if (cnt == BCW'(i)) begin
              shadow_next[byte_lsb(i, IR_BYTES, DATA_W) +: DATA_W] = DATA_IN;
            end
          end
          mar_inc  = 1'b1;
          cnt_next = cnt + BCW'(1);
          // Last byte: publish the whole word at once, including this byte.
          if (cnt == BCW'(IR_BYTES - 1)) begin
            ir_next    = shadow_next;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ir_mar_fetch.sv
// Self-checking bench for ir_mar_fetch: table-driven fetches on a 2-byte
// instance plus directed sequences, and 1-byte / 4-byte instances.
module tb_ir_mar_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HMAR, FETCH, MEM_ACK;
  logic [7:0]  BUS_C;
  logic        MEM_RD, IR_VALID, BUSY;
  logic [7:0]  BUS_DIR, DATA_IN;
  logic [15:0] IR_OUT;

  // Width instances: zero-wait memory, shared control inputs.
  logic        w_hmar, w_fetch;
  logic [7:0]  w_bus_c;
  logic        rd1, val1, busy1, rd4, val4, busy4;
  logic [7:0]  dir1, dir4, data1, data4;
  logic [7:0]  ir1;
  logic [31:0] ir4;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign DATA_IN = mem[BUS_DIR];
  assign data1   = mem[dir1];
  assign data4   = mem[dir4];

  ir_mar_fetch #(.DATA_W(8), .ADDR_W(8), .IR_BYTES(2), .RESET_ADDR(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .HMAR(HMAR), .BUS_C(BUS_C), .FETCH(FETCH),
    .MEM_RD(MEM_RD), .MEM_ACK(MEM_ACK), .DATA_IN(DATA_IN), .BUS_DIR(BUS_DIR),
    .IR_OUT(IR_OUT), .IR_VALID(IR_VALID), .BUSY(BUSY)
  );

  ir_mar_fetch #(.DATA_W(8), .ADDR_W(8), .IR_BYTES(1), .RESET_ADDR(8'h00)) dut1 (
    .CLK(CLK), .RESET(RESET), .HMAR(w_hmar), .BUS_C(w_bus_c), .FETCH(w_fetch),
    .MEM_RD(rd1), .MEM_ACK(rd1), .DATA_IN(data1), .BUS_DIR(dir1),
    .IR_OUT(ir1), .IR_VALID(val1), .BUSY(busy1)
  );

  ir_mar_fetch #(.DATA_W(8), .ADDR_W(8), .IR_BYTES(4), .RESET_ADDR(8'h00)) dut4 (
    .CLK(CLK), .RESET(RESET), .HMAR(w_hmar), .BUS_C(w_bus_c), .FETCH(w_fetch),
    .MEM_RD(rd4), .MEM_ACK(rd4), .DATA_IN(data4), .BUS_DIR(dir4),
    .IR_OUT(ir4), .IR_VALID(val4), .BUSY(busy4)
  );

  typedef struct {
    logic [7:0]  addr;
    int          waits;
    logic [15:0] exp_ir;
    logic [7:0]  exp_dir;
    int          exp_lat;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Load MAR, start a fetch, answer with `waits` idle cycles before each ACK.
  task automatic run_fetch(input logic [7:0] addr, input int waits, input logic [15:0] prev_ir,
                           output int lat, output int pulses, output logic [7:0] a0,
                           output logic [7:0] a1, output logic hold_ok, output logic ended_idle);
    int wc, nacc;
    HMAR = 1'b1; BUS_C = addr; tick();
    HMAR = 1'b0; FETCH = 1'b1; tick();
    FETCH = 1'b0;
    lat = 0; pulses = 0; wc = 0; nacc = 0; hold_ok = 1'b1; ended_idle = 1'b0;
    a0 = 8'hxx; a1 = 8'hxx;
    for (int c = 1; c <= 60; c++) begin
      if (IR_VALID) begin
        pulses++;
        if (lat == 0) lat = c;
      end else if (lat != 0) begin
        ended_idle = !BUSY && !MEM_RD;
        break;
      end else if (IR_OUT !== prev_ir) begin
        hold_ok = 1'b0;
      end
      MEM_ACK = 1'b0;
      if (MEM_RD) begin
        if (wc == waits) begin
          MEM_ACK = 1'b1;
          if (nacc == 0) a0 = BUS_DIR; else a1 = BUS_DIR;
          nacc++;
          wc = 0;
        end else begin
          wc++;
        end
      end
      tick();
    end
    MEM_ACK = 1'b0;
  endtask

  initial begin
    int lat, pulses, lat1, lat4;
    logic [7:0] a0, a1;
    logic hold_ok, ended_idle;
    logic [15:0] prev_exp;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hA5] = 8'h3C; mem[8'hA6] = 8'h99; mem[8'hA7] = 8'hDE; mem[8'hA8] = 8'hAD;
    mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    mem[8'h10] = 8'h55; mem[8'h11] = 8'h66;
    mem[8'h40] = 8'h77; mem[8'h41] = 8'h88;

    vecs[0] = '{addr: 8'hA5, waits: 0, exp_ir: 16'h3C99, exp_dir: 8'hA7, exp_lat: 3};
    vecs[1] = '{addr: 8'hA5, waits: 2, exp_ir: 16'h3C99, exp_dir: 8'hA7, exp_lat: 7};
    vecs[2] = '{addr: 8'hFF, waits: 0, exp_ir: 16'h1234, exp_dir: 8'h01, exp_lat: 3};

    RESET = 1'b1; HMAR = 1'b0; FETCH = 1'b0; MEM_ACK = 1'b0; BUS_C = 8'h00;
    w_hmar = 1'b0; w_fetch = 1'b0; w_bus_c = 8'h00;
    #12;
    tick();
    RESET = 1'b0;
    tick();

    // Reset state
    check("rst_bus_dir", 32'(BUS_DIR), 32'h00);
    check("rst_ir_out", 32'(IR_OUT), 32'h0000);
    check("rst_mem_rd", 32'(MEM_RD), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_ir_valid", 32'(IR_VALID), 32'h0);

    // Table-driven fetches
    prev_exp = 16'h0000;
    for (int v = 0; v < 3; v++) begin
      run_fetch(vecs[v].addr, vecs[v].waits, prev_exp, lat, pulses, a0, a1, hold_ok, ended_idle);
      check($sformatf("v%0d_ir_out", v), 32'(IR_OUT), 32'(vecs[v].exp_ir));
      check($sformatf("v%0d_bus_dir", v), 32'(BUS_DIR), 32'(vecs[v].exp_dir));
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("v%0d_valid_pulses", v), 32'(pulses), 32'd1);
      check($sformatf("v%0d_addr0", v), 32'(a0), 32'(vecs[v].addr));
      check($sformatf("v%0d_addr1", v), 32'(a1), 32'(8'(vecs[v].addr + 8'd1)));
      check($sformatf("v%0d_ir_hold", v), 32'(hold_ok), 32'h1);
      check($sformatf("v%0d_back_idle", v), 32'(ended_idle), 32'h1);
      prev_exp = vecs[v].exp_ir;
    end

    // HMAR / FETCH while busy and MEM_ACK in DONE are ignored
    HMAR = 1'b1; BUS_C = 8'h10; tick();
    HMAR = 1'b0; FETCH = 1'b1; tick();                       // cycle 1: REQ
    check("busy_req_rd", 32'(MEM_RD), 32'h1);
    HMAR = 1'b1; BUS_C = 8'hF0; FETCH = 1'b1; MEM_ACK = 1'b0; tick();
    check("busy_mar_kept", 32'(BUS_DIR), 32'h10);
    HMAR = 1'b0; FETCH = 1'b0; MEM_ACK = 1'b1; tick();       // byte 0 accepted
    FETCH = 1'b1; tick();                                    // byte 1 accepted
    check("busy_done_valid", 32'(IR_VALID), 32'h1);
    HMAR = 1'b1; BUS_C = 8'hF0; FETCH = 1'b1; MEM_ACK = 1'b1; tick();
    HMAR = 1'b0; FETCH = 1'b0; MEM_ACK = 1'b0;
    check("busy_ir_out", 32'(IR_OUT), 32'h5566);
    check("busy_bus_dir", 32'(BUS_DIR), 32'h12);
    check("busy_idle", 32'(BUSY), 32'h0);
    tick();
    check("busy_no_refetch", 32'(MEM_RD), 32'h0);
    check("busy_no_extra_byte", 32'(BUS_DIR), 32'h12);

    // Same-cycle HMAR + FETCH
    HMAR = 1'b1; BUS_C = 8'h40; FETCH = 1'b1; tick();
    HMAR = 1'b0; FETCH = 1'b0;
    check("hf_mem_rd", 32'(MEM_RD), 32'h1);
    check("hf_bus_dir", 32'(BUS_DIR), 32'h40);
    MEM_ACK = 1'b1; tick(); tick();
    MEM_ACK = 1'b0;
    check("hf_ir_valid", 32'(IR_VALID), 32'h1);
    check("hf_ir_out", 32'(IR_OUT), 32'h7788);
    tick();

    // Width generality: 1-byte and 4-byte instances
    w_hmar = 1'b1; w_bus_c = 8'hA5; tick();
    w_hmar = 1'b0; w_fetch = 1'b1; tick();
    w_fetch = 1'b0;
    lat1 = 0; lat4 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (val1 && lat1 == 0) lat1 = c;
      if (val4 && lat4 == 0) lat4 = c;
      if (lat1 != 0 && lat4 != 0) break;
      tick();
    end
    check("w1_latency", 32'(lat1), 32'd2);
    check("w1_ir_out", 32'(ir1), 32'h3C);
    check("w4_latency", 32'(lat4), 32'd5);
    check("w4_ir_out", ir4, 32'h3C99DEAD);
    check("w4_bus_dir", 32'(dir4), 32'hA9);

    // Reset asserted mid-fetch
    HMAR = 1'b1; BUS_C = 8'hA5; tick();
    HMAR = 1'b0; FETCH = 1'b1; tick();
    FETCH = 1'b0; MEM_ACK = 1'b1; tick();
    MEM_ACK = 1'b0;
    check("mid_busy", 32'(BUSY), 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    check("mid_rst_bus_dir", 32'(BUS_DIR), 32'h00);
    check("mid_rst_ir_out", 32'(IR_OUT), 32'h0000);
    check("mid_rst_mem_rd", 32'(MEM_RD), 32'h0);
    check("mid_rst_busy", 32'(BUSY), 32'h0);
    check("mid_rst_ir4", ir4, 32'h0);
    tick();
    RESET = 1'b0;
    tick();
    check("post_rst_idle", 32'(MEM_RD), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
